// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcode/funct3 constants, EX/MEM and MEM/WB words,
// and the memory-stage FSM state.
package rv32i_types;

  localparam logic [6:0] op_b_lui   = 7'b0110111;
  localparam logic [6:0] op_b_load  = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;
  localparam logic [6:0] op_b_imm   = 7'b0010011;
  localparam logic [6:0] op_b_reg   = 7'b0110011;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rd_v;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic        regf_we;
    logic        commit;
    logic        bubble;
    logic        req_dmem_resp;
    logic [1:0]  dmem_shift_bits;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rd_v;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic        regf_we;
    logic        commit;
    logic        bubble;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
  } mem_wb_reg_t;

  typedef enum logic {
    s_run  = 1'b0,
    s_wait = 1'b1
  } mem_state_t;

  function automatic mem_wb_reg_t mem_wb_bubble();
    mem_wb_reg_t b;
    b = '0;
    b.bubble = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword from a word-aligned
// read and sign- or zero-extends it according to funct3.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  shift_bits,
  input  logic [31:0] rdata,
  output logic [31:0] rd_v
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rdata[8*shift_bits +: 8];
  assign half_s = shift_bits[1] ? rdata[31:16] : rdata[15:0];

  // extend the selected lane to 32 bits
  always_comb begin
    rd_v = 32'h0000_0000;
    case (funct3)
      load_f3_lb:  rd_v = {{24{byte_s[7]}}, byte_s};
      load_f3_lbu: rd_v = {24'h00_0000, byte_s};
      load_f3_lh:  rd_v = {{16{half_s[15]}}, half_s};
      load_f3_lhu: rd_v = {16'h0000, half_s};
      load_f3_lw:  rd_v = rdata;
      default:     rd_v = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: waits for the data-memory response, aligns load data and
// registers the MEM/WB word. Optional watchdog: MEM_STAGE_WATCHDOG_EN.
module mem_stage
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_reg_t ex_mem_reg,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output mem_wb_reg_t mem_wb_reg,
  output logic        stall,
  output logic [4:0]  fwd_rd_s,
  output logic [31:0] fwd_rd_v,
  output logic        fwd_valid,
  output logic        dmem_timeout
);

  mem_state_t  state_r;
  logic        mem_op_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        completing_s;
  logic [31:0] load_data_s;
  mem_wb_reg_t wb_next_s;

  assign mem_op_s   = ex_mem_reg.req_dmem_resp & ~ex_mem_reg.bubble;
  assign is_load_s  = mem_op_s & (ex_mem_reg.opcode == op_b_load);
  assign is_store_s = mem_op_s & (ex_mem_reg.opcode == op_b_store);

  load_align u_load_align (
    .funct3     (ex_mem_reg.funct3),
    .shift_bits (ex_mem_reg.dmem_shift_bits),
    .rdata      (dmem_rdata),
    .rd_v       (load_data_s)
  );

  // handshake: stall depends only on FSM state, the EX/MEM word and the response
  always_comb begin
    if (state_r == s_wait) begin
      stall        = ~dmem_resp;
      completing_s = dmem_resp;
    end else begin
      stall        = mem_op_s & ~dmem_resp;
      completing_s = mem_op_s & dmem_resp;
    end
  end

  // build the MEM/WB word that is captured when the stage is not stalled
  always_comb begin
    wb_next_s            = '0;
    wb_next_s.pc         = ex_mem_reg.pc;
    wb_next_s.pc_next    = ex_mem_reg.pc_next;
    wb_next_s.inst       = ex_mem_reg.inst;
    wb_next_s.rd_s       = ex_mem_reg.rd_s;
    wb_next_s.rs1_s      = ex_mem_reg.rs1_s;
    wb_next_s.rs2_s      = ex_mem_reg.rs2_s;
    wb_next_s.rs1_v      = ex_mem_reg.rs1_v;
    wb_next_s.rs2_v      = ex_mem_reg.rs2_v;
    wb_next_s.funct3     = ex_mem_reg.funct3;
    wb_next_s.opcode     = ex_mem_reg.opcode;
    wb_next_s.bubble     = ex_mem_reg.bubble;
    wb_next_s.dmem_addr  = ex_mem_reg.dmem_addr;
    wb_next_s.dmem_rmask = ex_mem_reg.dmem_rmask;
    wb_next_s.dmem_wmask = ex_mem_reg.dmem_wmask;
    wb_next_s.dmem_wdata = ex_mem_reg.dmem_wdata;
    if (is_load_s) begin
      wb_next_s.rd_v       = load_data_s;
      wb_next_s.regf_we    = 1'b1;
      wb_next_s.commit     = 1'b1;
      wb_next_s.dmem_rdata = dmem_rdata;
    end else if (is_store_s) begin
      wb_next_s.rd_v       = ex_mem_reg.rd_v;
      wb_next_s.regf_we    = 1'b0;
      wb_next_s.commit     = 1'b1;
      wb_next_s.dmem_rdata = 32'h0000_0000;
    end else begin
      wb_next_s.rd_v       = ex_mem_reg.rd_v;
      wb_next_s.regf_we    = ex_mem_reg.regf_we;
      wb_next_s.commit     = ex_mem_reg.commit;
      wb_next_s.dmem_rdata = 32'h0000_0000;
    end
  end

  // forwarding: a load is only forwardable in the cycle its data arrives
  always_comb begin
    fwd_rd_s  = ex_mem_reg.rd_s;
    fwd_valid = ~ex_mem_reg.bubble & wb_next_s.regf_we & (ex_mem_reg.rd_s != 5'd0)
              & ~(is_load_s & ~completing_s);
    if (is_load_s && completing_s) begin
      fwd_rd_v = load_data_s;
    end else begin
      fwd_rd_v = ex_mem_reg.rd_v;
    end
  end

  // FSM and MEM/WB register; a stalled cycle sends a bubble to writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= s_run;
      mem_wb_reg <= mem_wb_bubble();
    end else begin
      case (state_r)
        s_run:   state_r <= (mem_op_s && !dmem_resp) ? s_wait : s_run;
        s_wait:  state_r <= dmem_resp ? s_run : s_wait;
        default: state_r <= s_run;
      endcase
      mem_wb_reg <= stall ? mem_wb_bubble() : wb_next_s;
    end
  end

`ifdef MEM_STAGE_WATCHDOG_EN
  localparam int unsigned wd_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [wd_w-1:0] wd_cnt_r;
  logic            dmem_timeout_r;

  // saturating wait-cycle counter with a sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r       <= '0;
      dmem_timeout_r <= 1'b0;
    end else if (state_r == s_wait) begin
      if (dmem_resp) begin
        wd_cnt_r <= '0;
      end else if (wd_cnt_r != wd_w'(TIMEOUT_CYCLES)) begin
        wd_cnt_r <= wd_cnt_r + wd_w'(1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (wd_cnt_r == wd_w'(TIMEOUT_CYCLES - 1)) begin
        dmem_timeout_r <= 1'b1;
      end else begin
        dmem_timeout_r <= dmem_timeout_r;
      end
    end else begin
      wd_cnt_r       <= '0;
      dmem_timeout_r <= dmem_timeout_r;
    end
  end

  assign dmem_timeout = dmem_timeout_r;
`else
  assign dmem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, stalls, reset in
// wait, stray responses and the optional watchdog.
module tb_mem_stage;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_mem_reg_t ex_mem_reg;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  mem_wb_reg_t mem_wb_reg;
  logic        stall;
  logic [4:0]  fwd_rd_s;
  logic [31:0] fwd_rd_v;
  logic        fwd_valid;
  logic        dmem_timeout;

  int checks   = 0;
  int failures = 0;

`ifdef MEM_STAGE_WATCHDOG_EN
  localparam logic wd_en = 1'b1;
`else
  localparam logic wd_en = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_mem_reg   (ex_mem_reg),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .mem_wb_reg   (mem_wb_reg),
    .stall        (stall),
    .fwd_rd_s     (fwd_rd_s),
    .fwd_rd_v     (fwd_rd_v),
    .fwd_valid    (fwd_valid),
    .dmem_timeout (dmem_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_reg_t mk_ex(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [1:0] sh, input logic [4:0] rd,
                                        input logic [31:0] rdv, input logic we,
                                        input logic req, input logic [31:0] addr);
    ex_mem_reg_t e;
    e = '0;
    e.pc              = 32'h0000_1000;
    e.pc_next         = 32'h0000_1004;
    e.inst            = 32'h0000_0013;
    e.opcode          = op;
    e.funct3          = f3;
    e.dmem_shift_bits = sh;
    e.rd_s            = rd;
    e.rd_v            = rdv;
    e.regf_we         = we;
    e.commit          = 1'b1;
    e.req_dmem_resp   = req;
    e.dmem_addr       = addr;
    e.dmem_rmask      = (op == op_b_load)  ? 4'hF : 4'h0;
    e.dmem_wmask      = (op == op_b_store) ? 4'b1100 : 4'h0;
    e.dmem_wdata      = (op == op_b_store) ? 32'hCAFE_0000 : 32'h0000_0000;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ex_mem_reg        = '0;
    ex_mem_reg.bubble = 1'b1;
    rst        = 1'b1;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0000_0000;
    tick();
    tick();
    check_eq("rst_bubble",  32'(mem_wb_reg.bubble),  32'd1);
    check_eq("rst_commit",  32'(mem_wb_reg.commit),  32'd0);
    check_eq("rst_we",      32'(mem_wb_reg.regf_we), 32'd0);
    check_eq("rst_rd_v",    mem_wb_reg.rd_v,         32'h0);
    check_eq("rst_stall",   32'(stall),              32'd0);
    check_eq("rst_timeout", 32'(dmem_timeout),       32'd0);
    rst = 1'b0;

    // lw, same-cycle response
    ex_mem_reg = mk_ex(op_b_load, load_f3_lw, 2'd0, 5'd5, 32'h0, 1'b1, 1'b1, 32'h0000_0100);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("lw_stall",     32'(stall),     32'd0);
    check_eq("lw_fwd_valid", 32'(fwd_valid), 32'd1);
    check_eq("lw_fwd_v",     fwd_rd_v,       32'hDEAD_BEEF);
    check_eq("lw_fwd_s",     32'(fwd_rd_s),  32'd5);
    tick();
    check_eq("lw_rd_v",   mem_wb_reg.rd_v,         32'hDEAD_BEEF);
    check_eq("lw_we",     32'(mem_wb_reg.regf_we), 32'd1);
    check_eq("lw_commit", 32'(mem_wb_reg.commit),  32'd1);
    check_eq("lw_bubble", 32'(mem_wb_reg.bubble),  32'd0);
    check_eq("lw_rdata",  mem_wb_reg.dmem_rdata,   32'hDEAD_BEEF);
    check_eq("lw_addr",   mem_wb_reg.dmem_addr,    32'h0000_0100);
    check_eq("lw_pc",     mem_wb_reg.pc,           32'h0000_1000);

    // lb shift 3, response after 3 stall cycles
    ex_mem_reg = mk_ex(op_b_load, load_f3_lb, 2'd3, 5'd6, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0000_0000;
    #1;
    check_eq("lb_fwd_pending", 32'(fwd_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("lb_stall", 32'(stall), 32'd1);
      tick();
      check_eq("lb_wb_bubble", 32'(mem_wb_reg.bubble), 32'd1);
      check_eq("lb_wb_commit", 32'(mem_wb_reg.commit), 32'd0);
    end
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80FF_0000;
    #1;
    check_eq("lb_stall_fall", 32'(stall),     32'd0);
    check_eq("lb_fwd_valid",  32'(fwd_valid), 32'd1);
    check_eq("lb_fwd_v",      fwd_rd_v,       32'hFFFF_FF80);
    tick();
    check_eq("lb_rd_v",   mem_wb_reg.rd_v,        32'hFFFF_FF80);
    check_eq("lb_commit", 32'(mem_wb_reg.commit), 32'd1);

    // lhu shift 2
    ex_mem_reg = mk_ex(op_b_load, load_f3_lhu, 2'd2, 5'd7, 32'h0, 1'b1, 1'b1, 32'h0000_0202);
    dmem_rdata = 32'hBEEF_1234;
    #1;
    check_eq("lhu_stall", 32'(stall), 32'd0);
    tick();
    check_eq("lhu_rd_v", mem_wb_reg.rd_v, 32'h0000_BEEF);

    // lh shift 0, negative half
    ex_mem_reg = mk_ex(op_b_load, load_f3_lh, 2'd0, 5'd7, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
    dmem_rdata = 32'h1234_8001;
    tick();
    check_eq("lh_rd_v", mem_wb_reg.rd_v, 32'hFFFF_8001);

    // lbu shift 1
    ex_mem_reg = mk_ex(op_b_load, load_f3_lbu, 2'd1, 5'd7, 32'h0, 1'b1, 1'b1, 32'h0000_0201);
    dmem_rdata = 32'h0000_9A00;
    tick();
    check_eq("lbu_rd_v", mem_wb_reg.rd_v, 32'h0000_009A);

    // sh store
    ex_mem_reg = mk_ex(op_b_store, 3'b001, 2'd2, 5'd0, 32'h0000_0055, 1'b0, 1'b1, 32'h0000_0202);
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("sh_fwd_valid", 32'(fwd_valid), 32'd0);
    tick();
    check_eq("sh_commit", 32'(mem_wb_reg.commit),     32'd1);
    check_eq("sh_we",     32'(mem_wb_reg.regf_we),    32'd0);
    check_eq("sh_rd_v",   mem_wb_reg.rd_v,            32'h0000_0055);
    check_eq("sh_rdata",  mem_wb_reg.dmem_rdata,      32'h0);
    check_eq("sh_wmask",  32'(mem_wb_reg.dmem_wmask), 32'hC);

    // reset while waiting, then stray response with an add in MEM
    ex_mem_reg = mk_ex(op_b_load, load_f3_lw, 2'd0, 5'd8, 32'h0, 1'b1, 1'b1, 32'h0000_0300);
    dmem_resp  = 1'b0;
    #1;
    check_eq("rw_stall", 32'(stall), 32'd1);
    tick();
    rst        = 1'b1;
    ex_mem_reg = mk_ex(op_b_reg, 3'b000, 2'd0, 5'd9, 32'h0000_0077, 1'b1, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    check_eq("rw_bubble", 32'(mem_wb_reg.bubble), 32'd1);
    check_eq("rw_commit", 32'(mem_wb_reg.commit), 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1111_2222;
    #1;
    check_eq("stray_stall",     32'(stall),     32'd0);
    check_eq("stray_fwd_v",     fwd_rd_v,       32'h0000_0077);
    check_eq("stray_fwd_valid", 32'(fwd_valid), 32'd1);
    tick();
    check_eq("stray_rd_v",   mem_wb_reg.rd_v,         32'h0000_0077);
    check_eq("stray_rdata",  mem_wb_reg.dmem_rdata,   32'h0);
    check_eq("stray_opcode", 32'(mem_wb_reg.opcode),  32'(op_b_reg));
    check_eq("stray_we",     32'(mem_wb_reg.regf_we), 32'd1);

    // rd = x0 never forwards
    ex_mem_reg = mk_ex(op_b_reg, 3'b000, 2'd0, 5'd0, 32'h0000_0042, 1'b1, 1'b0, 32'h0);
    dmem_resp  = 1'b0;
    #1;
    check_eq("x0_fwd_valid", 32'(fwd_valid), 32'd0);

    // long wait: watchdog (if built in) rises after 8 wait cycles
    ex_mem_reg = mk_ex(op_b_load, load_f3_lw, 2'd0, 5'd10, 32'h0, 1'b1, 1'b1, 32'h0000_0400);
    dmem_resp  = 1'b0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) check_eq("wd_before", 32'(dmem_timeout), 32'd0);
      if (i == 9) check_eq("wd_rise",   32'(dmem_timeout), 32'(wd_en));
      if (i == 10) check_eq("wd_stall", 32'(stall), 32'd1);
      if (i < 10) tick();
    end
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    #1;
    check_eq("wd_stall_fall", 32'(stall), 32'd0);
    tick();
    check_eq("wd_rd_v",   mem_wb_reg.rd_v,     32'h0BAD_F00D);
    check_eq("wd_sticky", 32'(dmem_timeout),   32'(wd_en));
    dmem_resp = 1'b0;
    ex_mem_reg        = '0;
    ex_mem_reg.bubble = 1'b1;
    tick();
    check_eq("wd_sticky2", 32'(dmem_timeout), 32'(wd_en));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
